// File: rtl/b16_pkg.sv
// Shared constants and owner encoding for the b16 bus blocks.
package b16_pkg;

  localparam int unsigned l     = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/b16_wait_counter.sv
// Wait-state counter: loads WAITS on a granted start cycle, then counts down.
module b16_wait_counter
  import b16_pkg::*;
#(
  parameter int unsigned WAITS = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic is_last
);

  localparam logic [CNT_W-1:0] WAITS_V = CNT_W'(WAITS);
  localparam logic             ZERO_WAIT = (WAITS == 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Decrement while busy, otherwise load the wait count on a granted start.
  always_comb begin
    cnt_d   = cnt_q;
    busy    = (cnt_q != '0);
    is_last = busy ? (cnt_q == CNT_W'(1)) : ZERO_WAIT;
    if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (load) begin
      cnt_d = WAITS_V;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/b16_mem_arbiter.sv
// Shares the b16 memory port between the CPU and one DMA/loader requester.
module b16_mem_arbiter
  import b16_pkg::*;
#(
  parameter int unsigned WAITS = 0,
  parameter int unsigned BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_in,
  output logic         cpu_run,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic [l-1:0] cpu_dout,
  output logic [l-1:0] cpu_din,
  input  logic         dma_req,
  input  logic [l-1:0] dma_addr,
  input  logic         dma_rd,
  input  logic [1:0]   dma_wr,
  input  logic [l-1:0] dma_dout,
  output logic [l-1:0] dma_din,
  output logic         dma_ack,
  output logic [l-1:0] mem_addr,
  output logic         mem_rd,
  output logic [1:0]   mem_wr,
  output logic [l-1:0] mem_dout,
  input  logic [l-1:0] mem_din
);

  localparam logic [CNT_W-1:0] BURST_V = CNT_W'(BURST);

  owner_e           owner_q, owner_d, owner_c;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             busy, is_last, load;
  logic             cpu_acc, start, grant_cpu, grant_dma, active;

  b16_wait_counter #(.WAITS(WAITS)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .busy    (busy),
    .is_last (is_last)
  );

  // Arbitration, owner/streak update and memory mux.
  always_comb begin
    owner_d   = owner_q;
    streak_d  = streak_q;
    cpu_acc   = run_in & (cpu_rd | (|cpu_wr));
    start     = ~busy;
    grant_cpu = start & cpu_acc & ~(dma_req & (streak_q < BURST_V));
    grant_dma = start & dma_req & ~grant_cpu;
    load      = grant_cpu | grant_dma;
    owner_c   = start ? (grant_dma ? OWN_DMA : OWN_CPU) : owner_q;
    active    = ~reset & (busy | load);

    if (load) begin
      owner_d = owner_c;
    end
    // Only contended DMA wins build the streak; stolen cycles leave it alone.
    if (grant_dma & cpu_acc) begin
      streak_d = (streak_q >= BURST_V) ? BURST_V : streak_q + CNT_W'(1);
    end
    if (grant_cpu) begin
      streak_d = '0;
    end

    mem_addr = (owner_c == OWN_DMA) ? dma_addr : cpu_addr;
    mem_dout = (owner_c == OWN_DMA) ? dma_dout : cpu_dout;
    mem_rd   = 1'b0;
    mem_wr   = 2'b00;
    if (active) begin
      if (owner_c == OWN_DMA) begin
        mem_rd = dma_rd;
        mem_wr = dma_rd ? 2'b00 : dma_wr;
      end else begin
        mem_rd = cpu_rd;
        mem_wr = cpu_rd ? 2'b00 : cpu_wr;
      end
    end

    // A CPU cycle without memory access runs regardless of who holds memory.
    cpu_run = ~reset & run_in &
              (~cpu_acc | (active & (owner_c == OWN_CPU) & is_last));
    dma_ack = active & (owner_c == OWN_DMA) & is_last;
    cpu_din = mem_din;
    dma_din = mem_din;
  end

  // Owner and DMA-streak registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_CPU;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_b16_mem_arbiter.sv
// Directed bench: four arbiters with WAITS=0..3 share one stimulus stream.
module tb_b16_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_in;
  logic [15:0] cpu_addr, cpu_dout, dma_addr, dma_dout;
  logic        cpu_rd, dma_req, dma_rd;
  logic [1:0]  cpu_wr, dma_wr;

  logic        cpu_run_w  [4];
  logic [15:0] cpu_din_w  [4];
  logic [15:0] dma_din_w  [4];
  logic        dma_ack_w  [4];
  logic [15:0] mem_addr_w [4];
  logic        mem_rd_w   [4];
  logic [1:0]  mem_wr_w   [4];
  logic [15:0] mem_dout_w [4];
  logic [15:0] mem_din_w  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    b16_mem_arbiter #(.WAITS(gi), .BURST(4)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .run_in   (run_in),
      .cpu_run  (cpu_run_w[gi]),
      .cpu_addr (cpu_addr),
      .cpu_rd   (cpu_rd),
      .cpu_wr   (cpu_wr),
      .cpu_dout (cpu_dout),
      .cpu_din  (cpu_din_w[gi]),
      .dma_req  (dma_req),
      .dma_addr (dma_addr),
      .dma_rd   (dma_rd),
      .dma_wr   (dma_wr),
      .dma_dout (dma_dout),
      .dma_din  (dma_din_w[gi]),
      .dma_ack  (dma_ack_w[gi]),
      .mem_addr (mem_addr_w[gi]),
      .mem_rd   (mem_rd_w[gi]),
      .mem_wr   (mem_wr_w[gi]),
      .mem_dout (mem_dout_w[gi]),
      .mem_din  (mem_din_w[gi])
    );
    // Memory model: read data is a fixed scramble of the address.
    assign mem_din_w[gi] = mem_addr_w[gi] ^ 16'hA5C3;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    run_in = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 2'b00; cpu_dout = '0;
    dma_req = 1'b0; dma_addr = '0; dma_rd = 1'b0; dma_wr = 2'b00; dma_dout = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    run_in = 1'b1; cpu_rd = 1'b1; dma_req = 1'b1; dma_rd = 1'b1;
    @(negedge clk);
    chk("rst_cpu_run", 16'(cpu_run_w[0]), 16'h0);
    chk("rst_dma_ack", 16'(dma_ack_w[0]), 16'h0);
    chk("rst_mem_rd",  16'(mem_rd_w[0]),  16'h0);
    chk("rst_mem_wr",  16'(mem_wr_w[3]),  16'h0);
    chk("rst_streak",  16'(g_dut[0].u_dut.streak_q), 16'h0);

    // 1: WAITS=0, CPU-only reads at 0x3FFE.
    do_reset();
    run_in = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h3FFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_cpu_run", 16'(cpu_run_w[0]), 16'h1);
      chk("t1_mem_rd",  16'(mem_rd_w[0]),  16'h1);
      chk("t1_cpu_din", cpu_din_w[0],      16'h9A3D);
      chk("t1_dma_ack", 16'(dma_ack_w[0]), 16'h0);
      next_cycle();
    end

    // 2: WAITS=2, read 0x0100 then byte write 0x1234.
    do_reset();
    run_in = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_rd_run",  16'(cpu_run_w[2]), (i == 2) ? 16'h1 : 16'h0);
      chk("t2_rd_mem",  16'(mem_rd_w[2]),  16'h1);
      chk("t2_rd_addr", mem_addr_w[2],     16'h0100);
      next_cycle();
    end
    cpu_rd = 1'b0; cpu_wr = 2'b01; cpu_dout = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_wr_run",  16'(cpu_run_w[2]), (i == 2) ? 16'h1 : 16'h0);
      chk("t2_wr_strb", 16'(mem_wr_w[2]),  16'h1);
      chk("t2_wr_data", mem_dout_w[2],     16'h1234);
      chk("t2_wr_rd",   16'(mem_rd_w[2]),  16'h0);
      next_cycle();
    end

    // 3: WAITS=0, BURST=4, both requesters continuous -> D,D,D,D,C.
    do_reset();
    run_in = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0010;
    dma_req = 1'b1; dma_rd = 1'b1; dma_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_dma_ack",  16'(dma_ack_w[0]), (i % 5 == 4) ? 16'h0 : 16'h1);
      chk("t3_cpu_run",  16'(cpu_run_w[0]), (i % 5 == 4) ? 16'h1 : 16'h0);
      chk("t3_mem_addr", mem_addr_w[0],     (i % 5 == 4) ? 16'h0010 : 16'h0020);
      next_cycle();
    end

    // 4: WAITS=1, CPU non-memory ops while DMA reads 0x2000.
    do_reset();
    run_in = 1'b1; dma_req = 1'b1; dma_rd = 1'b1; dma_addr = 16'h2000;
    @(negedge clk);
    chk("t4_c1_run",  16'(cpu_run_w[1]), 16'h1);
    chk("t4_c1_ack",  16'(dma_ack_w[1]), 16'h0);
    chk("t4_c1_rd",   16'(mem_rd_w[1]),  16'h1);
    chk("t4_c1_addr", mem_addr_w[1],     16'h2000);
    next_cycle();
    @(negedge clk);
    chk("t4_c2_run", 16'(cpu_run_w[1]), 16'h1);
    chk("t4_c2_ack", 16'(dma_ack_w[1]), 16'h1);
    chk("t4_c2_din", dma_din_w[1],      16'h85C3);
    next_cycle();
    dma_req = 1'b0;
    @(negedge clk);
    chk("t4_idle_rd",  16'(mem_rd_w[1]),  16'h0);
    chk("t4_idle_run", 16'(cpu_run_w[1]), 16'h1);
    chk("t4_streak",   16'(g_dut[1].u_dut.streak_q), 16'h0);
    next_cycle();

    // 5: WAITS=3, reset in the 2nd cycle of a contended DMA write.
    do_reset();
    run_in = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_rd = 1'b0; dma_wr = 2'b11; dma_addr = 16'h0300; dma_dout = 16'hBEEF;
    @(negedge clk);
    chk("t5_c1_wr",   16'(mem_wr_w[3]),  16'h3);
    chk("t5_c1_addr", mem_addr_w[3],     16'h0300);
    chk("t5_c1_ack",  16'(dma_ack_w[3]), 16'h0);
    next_cycle();
    @(negedge clk);
    chk("t5_c2_wr",   16'(mem_wr_w[3]),  16'h3);
    chk("t5_c2_data", mem_dout_w[3],     16'hBEEF);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_wr",     16'(mem_wr_w[3]),  16'h0);
    chk("t5_rst_ack",    16'(dma_ack_w[3]), 16'h0);
    chk("t5_rst_run",    16'(cpu_run_w[3]), 16'h0);
    chk("t5_rst_streak", 16'(g_dut[3].u_dut.streak_q), 16'h0);
    next_cycle();
    reset = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      chk("t5_re_ack", 16'(dma_ack_w[3]), (r == 4) ? 16'h1 : 16'h0);
      chk("t5_re_wr",  16'(mem_wr_w[3]),  16'h3);
      chk("t5_re_run", 16'(cpu_run_w[3]), 16'h0);
      next_cycle();
    end
    dma_req = 1'b0;
    chk("t5_streak", 16'(g_dut[3].u_dut.streak_q), 16'h1);

    // 6: run_in=0, DMA takes every access.
    do_reset();
    run_in = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_rd = 1'b1; dma_addr = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_w1_ack", 16'(dma_ack_w[1]), (i % 2 == 1) ? 16'h1 : 16'h0);
      chk("t6_w3_ack", 16'(dma_ack_w[3]), (i % 4 == 3) ? 16'h1 : 16'h0);
      chk("t6_run",    16'(cpu_run_w[1]), 16'h0);
      next_cycle();
    end
    chk("t6_w1_streak", 16'(g_dut[1].u_dut.streak_q), 16'h0);
    chk("t6_w3_streak", 16'(g_dut[3].u_dut.streak_q), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
